// File: rtl/muldiv_seq_pkg.sv
// Shared encodings for the iterative RV32M multiply/divide sequencer.
// Op codes match func3 so the execute stage can pass the field straight through.
package muldiv_seq_pkg;

  localparam int MD_XLEN = 32;

  typedef enum logic [2:0] {
    MD_OP_MUL    = 3'b000,
    MD_OP_MULH   = 3'b001,
    MD_OP_MULHSU = 3'b010,
    MD_OP_MULHU  = 3'b011,
    MD_OP_DIV    = 3'b100,
    MD_OP_DIVU   = 3'b101,
    MD_OP_REM    = 3'b110,
    MD_OP_REMU   = 3'b111
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } md_state_e;

endpackage

// File: rtl/muldiv_seq_if.sv
// Request/result bundle between the execute stage (master) and the M-extension unit (slave).
interface muldiv_seq_if #(parameter int XLEN = 32);
  logic            op_valid;
  logic            op_stall;
  logic            op_flush;
  logic [2:0]      op;
  logic [XLEN-1:0] op1;
  logic [XLEN-1:0] op2;
  logic            op_ready;
  logic [XLEN-1:0] op_out;

  modport master (
    output op_valid, op_stall, op_flush, op, op1, op2,
    input  op_ready, op_out
  );

  modport slave (
    input  op_valid, op_stall, op_flush, op, op1, op2,
    output op_ready, op_out
  );
endinterface

// File: rtl/muldiv_seq_step.sv
// One combinational iteration: LSB-first shift-add multiply or MSB-first restoring divide step.
// acc holds the running high product / partial remainder, lo the low product / dividend-quotient.
module muldiv_seq_step #(
  parameter int XLEN = 32
) (
  input  logic            is_div,
  input  logic [XLEN-1:0] acc,
  input  logic [XLEN-1:0] lo,
  input  logic [XLEN-1:0] opd,
  output logic [XLEN-1:0] acc_nxt,
  output logic [XLEN-1:0] lo_nxt
);

  logic [XLEN:0] sum;
  logic [XLEN:0] shl;
  logic [XLEN:0] diff;

  always_comb begin
    sum  = {1'b0, acc} + (lo[0] ? {1'b0, opd} : '0);
    shl  = {acc, lo[XLEN-1]};
    diff = shl - {1'b0, opd};
    if (is_div) begin
      // A clear borrow means the divisor fits: keep the difference and shift in a 1.
      if (!diff[XLEN]) begin
        acc_nxt = diff[XLEN-1:0];
        lo_nxt  = {lo[XLEN-2:0], 1'b1};
      end else begin
        acc_nxt = shl[XLEN-1:0];
        lo_nxt  = {lo[XLEN-2:0], 1'b0};
      end
    end else begin
      acc_nxt = sum[XLEN:1];
      lo_nxt  = {sum[0], lo[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// RV32M multiply/divide sequencer: XLEN-cycle iterative ops, one-cycle divide short-cuts,
// result held with op_ready until consumed (stall holds it, flush discards it).
module muldiv_seq
  import muldiv_seq_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic          clk,
  input  logic          rstn,
  muldiv_seq_if.slave   md,
  output logic          busy
);

  localparam int CNT_W = $clog2(XLEN);

  md_state_e       state, state_nxt;
  logic [CNT_W-1:0] cnt;
  md_op_e          op_q;
  logic            is_div_q;
  logic            neg_q;
  logic            neg_rem_q;
  logic [XLEN-1:0] acc, lo, opd;
  logic [XLEN-1:0] acc_nxt, lo_nxt;
  logic [XLEN-1:0] op_out_q;

  logic            accept, step_en, last;
  md_op_e          op_in;
  logic            is_div_in, s1, s2, neg1, neg2;
  logic            div_zero, div_ovf, shortcut;
  logic [XLEN-1:0] mag1, mag2, sc_res;
  logic [2*XLEN-1:0] prod, prod_fix;
  logic [XLEN-1:0] quo, rem, res;

  // Operand decode at accept: which inputs are signed, their magnitudes and short-cut results.
  always_comb begin
    op_in     = md_op_e'(md.op);
    is_div_in = md.op[2];
    s1        = is_div_in ? ~md.op[0] : (op_in != MD_OP_MULHU);
    s2        = is_div_in ? ~md.op[0] : (op_in == MD_OP_MUL || op_in == MD_OP_MULH);
    neg1      = s1 & md.op1[XLEN-1];
    neg2      = s2 & md.op2[XLEN-1];
    mag1      = neg1 ? -md.op1 : md.op1;
    mag2      = neg2 ? -md.op2 : md.op2;
    div_zero  = is_div_in & (md.op2 == '0);
    div_ovf   = is_div_in & ~md.op[0] & (md.op1 == {1'b1, {(XLEN-1){1'b0}}}) & (&md.op2);
    shortcut  = div_zero | div_ovf;
    if (div_zero) sc_res = md.op[1] ? md.op1 : '1;
    else          sc_res = md.op[1] ? '0 : md.op1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    step_en   = 1'b0;
    last      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (md.op_valid && !md.op_flush) begin
          accept    = 1'b1;
          state_nxt = shortcut ? ST_DONE : ST_CALC;
        end
      end
      ST_CALC: begin
        if (md.op_flush) begin
          state_nxt = ST_IDLE;
        end else begin
          step_en = 1'b1;
          if (cnt == CNT_W'(XLEN-1)) begin
            last      = 1'b1;
            state_nxt = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        if (md.op_flush || (md.op_valid && !md.op_stall)) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  muldiv_seq_step #(.XLEN(XLEN)) u_step (
    .is_div  (is_div_q),
    .acc     (acc),
    .lo      (lo),
    .opd     (opd),
    .acc_nxt (acc_nxt),
    .lo_nxt  (lo_nxt)
  );

  // Sign correction uses the step outputs so the last iteration registers the final result.
  always_comb begin
    prod     = {acc_nxt, lo_nxt};
    prod_fix = neg_q ? -prod : prod;
    quo      = neg_q ? -lo_nxt : lo_nxt;
    rem      = neg_rem_q ? -acc_nxt : acc_nxt;
    case (op_q)
      MD_OP_MUL:                           res = prod_fix[XLEN-1:0];
      MD_OP_MULH, MD_OP_MULHSU, MD_OP_MULHU: res = prod_fix[2*XLEN-1:XLEN];
      MD_OP_DIV, MD_OP_DIVU:               res = quo;
      default:                             res = rem;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt       <= '0;
      op_q      <= MD_OP_MUL;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      acc       <= '0;
      lo        <= '0;
      opd       <= '0;
      op_out_q  <= '0;
    end else if (accept) begin
      cnt       <= '0;
      op_q      <= op_in;
      is_div_q  <= is_div_in;
      neg_q     <= neg1 ^ neg2;
      neg_rem_q <= is_div_in & neg1;
      acc       <= '0;
      lo        <= is_div_in ? mag1 : mag2;
      opd       <= is_div_in ? mag2 : mag1;
      if (shortcut) op_out_q <= sc_res;
    end else if (step_en) begin
      acc <= acc_nxt;
      lo  <= lo_nxt;
      if (last) op_out_q <= res;
      else      cnt      <= cnt + 1'b1;
    end
  end

  assign md.op_ready = (state == ST_DONE);
  assign md.op_out   = op_out_q;
  assign busy        = (state != ST_IDLE);

endmodule
